// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the sound effect stage.
//   - state_t    : FSM state encoding (IDLE=0, TONE1=1, TONE2=2)
//   - TONE_ID_*  : values driven on sound_fx.tone_id
//   - DEF_*      : default tone timing for a 25 MHz clock
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE1 = 2'd1,
        TONE2 = 2'd2
    } state_t;

    localparam logic [1:0] TONE_ID_NONE = 2'd0;
    localparam logic [1:0] TONE_ID_1    = 2'd1;
    localparam logic [1:0] TONE_ID_2    = 2'd2;

    // 500 Hz, 1 kHz and 100 ms at 25 MHz
    localparam int DEF_TONE1_HALF = 25000;
    localparam int DEF_TONE2_HALF = 12500;
    localparam int DEF_DURATION   = 2500000;
    localparam int DEF_HALF_W     = 16;
    localparam int DEF_DUR_W      = 22;

endpackage

// File: rtl/tone_divider.sv
// tone_divider: square-wave generator with a programmable half-period.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   restart    : start a fresh wave (counter to 0, sq high)
//   enable     : advance the wave this cycle; when low (and no restart)
//                the wave is parked low with the counter cleared
//   half       : half-period in clk cycles, sampled while counting
//   sq         : registered square wave
module tone_divider #(
    parameter int HALF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              enable,
    input  logic [HALF_W-1:0] half,
    output logic              sq
);

    logic [HALF_W-1:0] half_cnt;
    logic [HALF_W-1:0] half_cnt_next;
    logic              sq_next;
    logic              wrap;

    assign wrap = (half_cnt == (half - HALF_W'(1)));

    always_comb begin
        half_cnt_next = half_cnt;
        sq_next       = sq;
        if (restart) begin
            half_cnt_next = '0;
            sq_next       = 1'b1;
        end else if (enable) begin
            if (wrap) begin
                half_cnt_next = '0;
                sq_next       = ~sq;
            end else begin
                half_cnt_next = half_cnt + HALF_W'(1);
            end
        end else begin
            // Not playing: keep the pin quiet and ready for the next tone.
            half_cnt_next = '0;
            sq_next       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt <= '0;
            sq       <= 1'b0;
        end else begin
            half_cnt <= half_cnt_next;
            sq       <= sq_next;
        end
    end

endmodule

// File: rtl/sound_fx.sv
// sound_fx: turns ball-controller sound requests into fixed-length square
// wave tones on one speaker pin. Tone 2 (paddle) outranks tone 1
// (wall/brick); one interrupted or colliding tone 1 is queued and played in
// full after tone 2.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   play_sound1  : tone 1 request, rising-edge triggered
//   play_sound2  : tone 2 request, rising-edge triggered
//   mute         : silences speaker from the next edge; timing continues
//   speaker      : square-wave audio output
//   busy         : high while a tone plays
//   tone_id      : 0 none, 1 tone 1, 2 tone 2 (mirrors the FSM state)
module sound_fx
    import sound_pkg::*;
#(
    parameter int TONE1_HALF = DEF_TONE1_HALF,
    parameter int TONE2_HALF = DEF_TONE2_HALF,
    parameter int DURATION   = DEF_DURATION,
    parameter int HALF_W     = DEF_HALF_W,
    parameter int DUR_W      = DEF_DUR_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_sound1,
    input  logic       play_sound2,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] tone_id
);

    localparam logic [HALF_W-1:0] T1_HALF  = HALF_W'(TONE1_HALF);
    localparam logic [HALF_W-1:0] T2_HALF  = HALF_W'(TONE2_HALF);
    localparam logic [DUR_W-1:0]  DUR_LAST = DUR_W'(DURATION - 1);

    logic              in1_q;
    logic              in2_q;
    logic              req1;
    logic              req2;
    state_t            state;
    state_t            state_d;
    logic              pend1;
    logic              pend1_d;
    logic              restart;
    logic              tone_en;
    logic              dur_end;
    logic [DUR_W-1:0]  dur_cnt;
    logic [HALF_W-1:0] half_sel;
    logic              sq;
    logic              mute_q;

    // A held request yields a single event; it must drop to retrigger.
    assign req1    = play_sound1 & ~in1_q;
    assign req2    = play_sound2 & ~in2_q;
    assign dur_end = (dur_cnt == DUR_LAST);

    // Requests are served before expiry: a request landing on the last
    // cycle of a tone restarts or switches instead of letting it end.
    always_comb begin
        state_d = state;
        pend1_d = pend1;
        restart = 1'b0;
        case (state)
            IDLE: begin
                if (req2) begin
                    state_d = TONE2;
                    restart = 1'b1;
                    if (req1) pend1_d = 1'b1;
                end else if (req1) begin
                    state_d = TONE1;
                    restart = 1'b1;
                end
            end
            TONE1: begin
                if (req2) begin
                    // Preempted tone 1 is replayed from the start later.
                    state_d = TONE2;
                    restart = 1'b1;
                    pend1_d = 1'b1;
                end else if (req1) begin
                    restart = 1'b1;
                end else if (dur_end) begin
                    state_d = IDLE;
                end
            end
            TONE2: begin
                if (req2) begin
                    restart = 1'b1;
                    if (req1) pend1_d = 1'b1;
                end else if (dur_end) begin
                    if (pend1 || req1) begin
                        state_d = TONE1;
                        restart = 1'b1;
                        pend1_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req1) begin
                    pend1_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pend1_d = 1'b0;
            end
        endcase
    end

    assign tone_en  = (state_d != IDLE);
    // Only matters while counting, when state and state_d agree.
    assign half_sel = (state == TONE2) ? T2_HALF : T1_HALF;

    always_ff @(posedge clk) begin
        if (reset) begin
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            state   <= IDLE;
            pend1   <= 1'b0;
            dur_cnt <= '0;
            mute_q  <= 1'b0;
        end else begin
            in1_q   <= play_sound1;
            in2_q   <= play_sound2;
            state   <= state_d;
            pend1   <= pend1_d;
            mute_q  <= mute;
            if (restart || !tone_en) begin
                dur_cnt <= '0;
            end else begin
                dur_cnt <= dur_cnt + DUR_W'(1);
            end
        end
    end

    tone_divider #(
        .HALF_W(HALF_W)
    ) u_tone_divider (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .enable  (tone_en),
        .half    (half_sel),
        .sq      (sq)
    );

    // Both terms come straight from flops updated on the same edge, so the
    // pin changes at the edge where the wave or the mute request changes.
    assign speaker = sq & ~mute_q;
    assign busy    = (state != IDLE);

    always_comb begin
        tone_id = TONE_ID_NONE;
        case (state)
            TONE1:   tone_id = TONE_ID_1;
            TONE2:   tone_id = TONE_ID_2;
            default: tone_id = TONE_ID_NONE;
        endcase
    end

endmodule
